// File: rtl/clock_disp_pkg.sv
// Shared constants for the clock display scan: segment patterns, digit positions
// and the binary-to-BCD digit split.
package clock_disp_pkg;

  localparam int unsigned NUM_DIGITS = 6;

  // Active-low patterns ordered {g,f,e,d,c,b,a}.
  localparam logic [6:0] SEG_DIGIT [0:9] = '{
    7'b1000000,  // 0
    7'b1111001,  // 1
    7'b0100100,  // 2
    7'b0110000,  // 3
    7'b0011001,  // 4
    7'b0010010,  // 5
    7'b0000010,  // 6
    7'b1111000,  // 7
    7'b0000000,  // 8
    7'b0010000   // 9
  };
  localparam logic [6:0] SEG_DASH  = 7'b0111111;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  // Anode positions, right to left on the HH.MM.SS display.
  localparam logic [2:0] DIG_SEC_ONES = 3'd0;
  localparam logic [2:0] DIG_SEC_TENS = 3'd1;
  localparam logic [2:0] DIG_MIN_ONES = 3'd2;
  localparam logic [2:0] DIG_MIN_TENS = 3'd3;
  localparam logic [2:0] DIG_HR_ONES  = 3'd4;
  localparam logic [2:0] DIG_HR_TENS  = 3'd5;

  function automatic logic [3:0] tens_of(input logic [5:0] v);
    return 4'(v / 6'd10);
  endfunction

  function automatic logic [3:0] ones_of(input logic [5:0] v);
    return 4'(v % 6'd10);
  endfunction

endpackage

// File: rtl/clock_display_scan_seg7_encode.sv
// BCD to active-low seven-segment pattern; non-decimal codes show a dash.
module seg7_encode
  import clock_disp_pkg::*;
(
  input  logic [3:0] bcd_i,
  output logic [6:0] seg_o
);

  // Table lookup with explicit constant indices.
  always_comb begin
    seg_o = SEG_DASH;
    case (bcd_i)
      4'd0:    seg_o = SEG_DIGIT[0];
      4'd1:    seg_o = SEG_DIGIT[1];
      4'd2:    seg_o = SEG_DIGIT[2];
      4'd3:    seg_o = SEG_DIGIT[3];
      4'd4:    seg_o = SEG_DIGIT[4];
      4'd5:    seg_o = SEG_DIGIT[5];
      4'd6:    seg_o = SEG_DIGIT[6];
      4'd7:    seg_o = SEG_DIGIT[7];
      4'd8:    seg_o = SEG_DIGIT[8];
      4'd9:    seg_o = SEG_DIGIT[9];
      default: seg_o = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/clock_display_scan.sv
// Six-digit multiplexed HH.MM.SS display driver. Snapshots the time once per
// scan so a scan never mixes old and new values, supports 12/24-hour display
// and blanks all anodes for a short guard at the start of each digit slot.
module clock_display_scan
  import clock_disp_pkg::*;
#(
  parameter int unsigned REFRESH_DIV = 100000,
  parameter int unsigned GUARD       = 4
) (
  input  logic       clk_i,
  input  logic       reset_ni,
  input  logic [4:0] hour_i,
  input  logic [5:0] min_i,
  input  logic [5:0] sec_i,
  input  logic       fmt12_i,
  output logic [5:0] an_o,
  output logic [6:0] seg_o,
  output logic       dp_o
);

  localparam int unsigned PreW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [PreW-1:0] PreMax   = PreW'(REFRESH_DIV - 1);
  localparam logic [PreW-1:0] GuardVal = PreW'(GUARD);

  logic [PreW-1:0] pre_q, pre_d;
  logic [2:0]      dig_q, dig_d;
  logic            load_pend_q;
  logic [4:0]      hour_q;
  logic [5:0]      min_q, sec_q;
  logic            fmt12_q;
  logic [5:0]      an_q, an_d;
  logic [6:0]      seg_q, seg_d;
  logic            dp_q, dp_d;

  logic            pre_wrap;
  logic            snap_load;

  logic            hour_ok, min_ok, sec_ok;
  logic [4:0]      hour_disp;
  logic            pm;
  logic [3:0]      hr_tens, hr_ones;

  logic [3:0]      bcd;
  logic            dash, blank;
  logic [6:0]      enc_seg;

  // Prescaler and scan counter; snapshot loads at the end of a full scan or
  // on the first edge out of reset.
  always_comb begin
    pre_wrap  = (pre_q == PreMax);
    pre_d     = pre_wrap ? '0 : pre_q + 1'b1;
    dig_d     = dig_q;
    if (pre_wrap) begin
      dig_d = (dig_q == DIG_HR_TENS) ? DIG_SEC_ONES : dig_q + 3'd1;
    end
    snap_load = load_pend_q || (pre_wrap && (dig_q == DIG_HR_TENS));
  end

  // Range check and 12/24-hour conversion of the snapshot.
  always_comb begin
    hour_ok   = (hour_q <= 5'd24);
    min_ok    = (min_q <= 6'd59);
    sec_ok    = (sec_q <= 6'd59);
    hour_disp = hour_q;
    if (fmt12_q) begin
      if (hour_q == 5'd0 || hour_q == 5'd12 || hour_q == 5'd24) begin
        hour_disp = 5'd12;
      end else if (hour_q >= 5'd13 && hour_q <= 5'd23) begin
        hour_disp = hour_q - 5'd12;
      end
    end
    pm      = fmt12_q && (hour_q >= 5'd12) && (hour_q <= 5'd23);
    hr_tens = tens_of({1'b0, hour_disp});
    hr_ones = ones_of({1'b0, hour_disp});
  end

  // Select the BCD value, overrides and decimal point for the current digit.
  always_comb begin
    bcd   = 4'd0;
    dash  = 1'b0;
    blank = 1'b0;
    dp_d  = 1'b1;
    case (dig_q)
      DIG_SEC_ONES: begin
        bcd  = ones_of(sec_q);
        dash = !sec_ok;
        dp_d = !pm;
      end
      DIG_SEC_TENS: begin
        bcd  = tens_of(sec_q);
        dash = !sec_ok;
      end
      DIG_MIN_ONES: begin
        bcd  = ones_of(min_q);
        dash = !min_ok;
        dp_d = 1'b0;
      end
      DIG_MIN_TENS: begin
        bcd  = tens_of(min_q);
        dash = !min_ok;
      end
      DIG_HR_ONES: begin
        bcd  = hr_ones;
        dash = !hour_ok;
        dp_d = 1'b0;
      end
      DIG_HR_TENS: begin
        bcd   = hr_tens;
        dash  = !hour_ok;
        // Leading zero suppression only in 12-hour mode.
        blank = fmt12_q && hour_ok && (hr_tens == 4'd0);
      end
      default: blank = 1'b1;
    endcase
  end

  seg7_encode u_seg7_encode (
    .bcd_i (bcd),
    .seg_o (enc_seg)
  );

  // Segment priority and anode gating for the registered outputs.
  always_comb begin
    if (blank) begin
      seg_d = SEG_BLANK;
    end else if (dash) begin
      seg_d = SEG_DASH;
    end else begin
      seg_d = enc_seg;
    end
    if (pre_q < GuardVal) begin
      an_d = '1;
    end else begin
      an_d = ~(6'b000001 << dig_q);
    end
  end

  // All state: scan counters, snapshot and output registers.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      pre_q       <= '0;
      dig_q       <= DIG_SEC_ONES;
      load_pend_q <= 1'b1;
      hour_q      <= '0;
      min_q       <= '0;
      sec_q       <= '0;
      fmt12_q     <= 1'b0;
      an_q        <= '1;
      seg_q       <= SEG_BLANK;
      dp_q        <= 1'b1;
    end else begin
      pre_q       <= pre_d;
      dig_q       <= dig_d;
      load_pend_q <= 1'b0;
      if (snap_load) begin
        hour_q  <= hour_i;
        min_q   <= min_i;
        sec_q   <= sec_i;
        fmt12_q <= fmt12_i;
      end
      an_q        <= an_d;
      seg_q       <= seg_d;
      dp_q        <= dp_d;
    end
  end

  assign an_o  = an_q;
  assign seg_o = seg_q;
  assign dp_o  = dp_q;

endmodule

// File: tb/tb_clock_display_scan.sv
// Scoreboard bench for clock_display_scan: the stimulus pushes the six expected
// digit slots of each scan it sets up, and a monitor pops one entry each time a
// digit slot lights up.
module tb_clock_display_scan;

  localparam int unsigned RDIV  = 8;
  localparam int unsigned GRD   = 2;
  localparam int          SCAN  = 48;
  localparam int          DASH  = 10;
  localparam int          BLANK = 11;

  logic       clk = 1'b0;
  logic       reset_ni = 1'b1;
  logic [4:0] hour_i = '0;
  logic [5:0] min_i = '0;
  logic [5:0] sec_i = '0;
  logic       fmt12_i = 1'b0;
  logic [5:0] an_o;
  logic [6:0] seg_o;
  logic       dp_o;

  typedef struct {
    logic [5:0] an;
    logic [6:0] seg;
    logic       dp;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_pass = 0;
  int   ncyc = 0;

  clock_display_scan #(
    .REFRESH_DIV (RDIV),
    .GUARD       (GRD)
  ) dut (
    .clk_i    (clk),
    .reset_ni (reset_ni),
    .hour_i   (hour_i),
    .min_i    (min_i),
    .sec_i    (sec_i),
    .fmt12_i  (fmt12_i),
    .an_o     (an_o),
    .seg_o    (seg_o),
    .dp_o     (dp_o)
  );

  always #5 clk = ~clk;

  // Edges since reset release; edge 1 and every edge 48k load the snapshot.
  always @(posedge clk or negedge reset_ni) begin
    if (!reset_ni) ncyc <= 0;
    else           ncyc <= ncyc + 1;
  end

  function automatic logic [6:0] sd(input int d);
    case (d)
      0:       return 7'b1000000;
      1:       return 7'b1111001;
      2:       return 7'b0100100;
      3:       return 7'b0110000;
      4:       return 7'b0011001;
      5:       return 7'b0010010;
      6:       return 7'b0000010;
      7:       return 7'b1111000;
      8:       return 7'b0000000;
      9:       return 7'b0010000;
      DASH:    return 7'b0111111;
      default: return 7'b1111111;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    $display("FAIL %s: wait bound expired", name);
  endtask

  // Digits listed from seconds ones (d0) to hour tens (d5).
  task automatic push_scan(input int d0, input int d1, input int d2, input int d3,
                           input int d4, input int d5, input bit pm);
    int         dd[6];
    exp_t       e;
    logic [5:0] one;
    dd  = '{d0, d1, d2, d3, d4, d5};
    one = 6'b000001;
    for (int k = 0; k < 6; k++) begin
      e.an  = ~(one << k);
      e.seg = sd(dd[k]);
      e.dp  = (k == 2 || k == 4) ? 1'b0 : ((k == 0) ? !pm : 1'b1);
      q.push_back(e);
    end
  endtask

  task automatic wait_phase(input int ph, input string name);
    int b = 0;
    do begin
      @(negedge clk);
      b++;
    end while ((ncyc % SCAN) != ph && b < 200);
    if (b >= 200) fail_now(name);
  endtask

  // Drive new inputs just before a snapshot edge and queue that scan's digits.
  task automatic load_scan(input int h, input int m, input int s, input bit f,
                           input int d0, input int d1, input int d2, input int d3,
                           input int d4, input int d5, input bit pm);
    wait_phase(SCAN - 1, "preload");
    hour_i  = 5'(h);
    min_i   = 6'(m);
    sec_i   = 6'(s);
    fmt12_i = f;
    push_scan(d0, d1, d2, d3, d4, d5, pm);
  endtask

  task automatic wait_drain(input string name);
    int b = 0;
    while (q.size() != 0 && b < 200) begin
      @(negedge clk);
      b++;
    end
    if (q.size() != 0) fail_now(name);
  endtask

  // Monitor: a slot starts when the anodes leave all-ones.
  initial begin
    logic [5:0] prev_an;
    bit         active;
    int         lit;
    exp_t       e;
    prev_an = '1;
    active  = 0;
    lit     = 0;
    forever begin
      @(negedge clk);
      if (reset_ni) begin
        if (an_o != 6'h3F && prev_an == 6'h3F) begin
          lit = 1;
          if (q.size() > 0) begin
            e = q.pop_front();
            check("slot anode", 32'(an_o), 32'(e.an));
            check("slot segments", 32'(seg_o), 32'(e.seg));
            check("slot dp", 32'(dp_o), 32'(e.dp));
            active = 1;
          end else begin
            active = 0;
          end
        end else if (an_o != 6'h3F) begin
          lit++;
        end else if (prev_an != 6'h3F && active) begin
          check("slot lit cycles", 32'(lit), 32'(RDIV - GRD));
          active = 0;
        end
      end
      prev_an = an_o;
    end
  end

  initial begin
    #1 reset_ni = 1'b0;
    #1;
    check("reset an", 32'(an_o), 32'h3F);
    check("reset seg", 32'(seg_o), 32'h7F);
    check("reset dp", 32'(dp_o), 32'h1);
    push_scan(0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    @(negedge clk);
    reset_ni = 1'b1;

    // 24-hour 23:45:07.
    load_scan(23, 45, 7, 0, 7, 0, 5, 4, 3, 2, 0);
    // 12-hour: 0 -> 12 AM, 12 -> 12 PM, 13 -> 1 PM blank tens, 24 -> 12 AM.
    load_scan(0, 34, 56, 1, 6, 5, 4, 3, 2, 1, 0);
    load_scan(12, 34, 56, 1, 6, 5, 4, 3, 2, 1, 1);
    load_scan(13, 34, 56, 1, 6, 5, 4, 3, 1, BLANK, 1);
    load_scan(24, 34, 56, 1, 6, 5, 4, 3, 2, 1, 0);
    // Mid-scan seconds change must not tear the current scan.
    load_scan(10, 20, 7, 0, 7, 0, 0, 2, 0, 1, 0);
    wait_phase(24, "midscan");
    sec_i = 6'd59;
    load_scan(10, 20, 59, 0, 9, 5, 0, 2, 0, 1, 0);
    // Out-of-range minutes.
    load_scan(10, 63, 59, 0, 9, 5, DASH, DASH, 0, 1, 0);

    // Reset in the middle of digit 3's lit window of an unchecked scan.
    wait_drain("drain before reset");
    wait_phase(29, "reset point");
    check("digit 3 lit before reset", 32'(an_o), 32'h37);
    #2 reset_ni = 1'b0;
    #1;
    check("async reset an", 32'(an_o), 32'h3F);
    check("async reset seg", 32'(seg_o), 32'h7F);
    check("async reset dp", 32'(dp_o), 32'h1);
    hour_i  = 5'd5;
    min_i   = 6'd6;
    sec_i   = 6'd7;
    fmt12_i = 1'b0;
    push_scan(7, 0, 6, 0, 5, 0, 0);
    repeat (3) @(negedge clk);
    reset_ni = 1'b1;

    wait_drain("final drain");
    repeat (10) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
